usbh_frame_scheduler: RTL and testbench

USBH_FRAME_SCHEDULER -- requirements
Module: usbh_frame_scheduler

---
 rtl/usbh_sched_pkg.sv | 17 +
 rtl/usbh_crc5.sv | 25 ++
 rtl/usbh_frame_scheduler.sv | 130 +++++++++++++
 tb/tb_usbh_frame_scheduler.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/usbh_sched_pkg.sv
// Shared types and constants for the USB host frame scheduler.
// Holds the FSM state encoding, the SOF PID and the CRC5 generator constants.
package usbh_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SOF_PID = 3'd1,
    ST_SOF_B1  = 3'd2,
    ST_SOF_B2  = 3'd3,
    ST_XFER    = 3'd4
  } sched_state_t;

  localparam logic [7:0] PID_SOF   = 8'hA5;
  localparam logic [4:0] CRC5_POLY = 5'b00101;
  localparam logic [4:0] CRC5_SEED = 5'b11111;

endpackage

// File: rtl/usbh_crc5.sv
// Combinational USB CRC5 over an 11-bit token field, LSB first.
// Output is inverted and bit-reversed so the first-sent CRC bit lands in bit 0.
module usbh_crc5
  import usbh_sched_pkg::*;
(
  input  logic [10:0] data,
  output logic [4:0]  crc
);

  logic [4:0] lfsr;
  logic       fb;

  always_comb begin
    lfsr = CRC5_SEED;
    fb   = 1'b0;
    for (int i = 0; i < 11; i++) begin
      fb   = lfsr[4] ^ data[i];
      lfsr = {lfsr[3:0], 1'b0} ^ (fb ? CRC5_POLY : 5'b00000);
    end
    for (int j = 0; j < 5; j++) begin
      crc[j] = ~lfsr[4-j];
    end
  end

endmodule

// File: rtl/usbh_frame_scheduler.sv
// USB host frame scheduler: 1 ms frame timer, SOF packet generation and
// arbitration of the UTMI TX path between SOF and the transfer engine.
module usbh_frame_scheduler
  import usbh_sched_pkg::*;
#(
  parameter int USB_CLK_FREQ = 48000000,
  parameter int EOF_GUARD    = 1200
) (
  input  logic        clk_i,
  input  logic        n_rst_i,
  input  logic        sof_en_i,
  input  logic        xfer_req_i,
  output logic        xfer_gnt_o,
  input  logic        xfer_done_i,
  input  logic [7:0]  xfer_data_i,
  input  logic        xfer_txvalid_i,
  output logic        xfer_txready_o,
  output logic [7:0]  utmi_data_o,
  output logic        utmi_txvalid_o,
  input  logic        utmi_txready_i,
  output logic [10:0] frame_o,
  output logic        sof_o,
  output logic        sof_late_o
);

  localparam int FRAME_CYCLES = USB_CLK_FREQ / 1000;
  localparam int TW           = $clog2(FRAME_CYCLES);
  localparam logic [TW-1:0] TIMER_LAST  = TW'(FRAME_CYCLES - 1);
  localparam logic [TW-1:0] GUARD_START = TW'(FRAME_CYCLES - EOF_GUARD);

  sched_state_t  state, state_nxt;
  logic [TW-1:0] timer;
  logic          sof_en_q;
  logic          sof_due;
  logic          sof_set;
  logic          sof_accept;
  logic [4:0]    crc5;

  usbh_crc5 u_crc5 (
    .data (frame_o),
    .crc  (crc5)
  );

  // A rising enable behaves like a wrap so the first SOF goes out at once.
  assign sof_set    = sof_en_i && ((timer == TIMER_LAST) || !sof_en_q);
  assign sof_accept = (state == ST_SOF_B2) && utmi_txready_i;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (sof_due)
          state_nxt = ST_SOF_PID;
        else if (xfer_req_i && (timer < GUARD_START))
          state_nxt = ST_XFER;
      end
      ST_SOF_PID: if (utmi_txready_i) state_nxt = ST_SOF_B1;
      ST_SOF_B1:  if (utmi_txready_i) state_nxt = ST_SOF_B2;
      ST_SOF_B2:  if (utmi_txready_i) state_nxt = ST_IDLE;
      ST_XFER:    if (xfer_done_i)    state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      state      <= ST_IDLE;
      timer      <= '0;
      sof_en_q   <= 1'b0;
      sof_due    <= 1'b0;
      frame_o    <= '0;
      sof_o      <= 1'b0;
      sof_late_o <= 1'b0;
    end else begin
      state    <= state_nxt;
      sof_en_q <= sof_en_i;
      sof_o    <= sof_accept;

      if (!sof_en_i)
        timer <= '0;
      else if (timer == TIMER_LAST)
        timer <= '0;
      else
        timer <= timer + 1'b1;

      // Dropping the enable discards any pending SOF; an in-flight packet still completes.
      if (!sof_en_i)
        sof_due <= 1'b0;
      else if (sof_set)
        sof_due <= 1'b1;
      else if ((state_nxt == ST_SOF_PID) && (state != ST_SOF_PID))
        sof_due <= 1'b0;

      if (sof_accept)
        frame_o <= frame_o + 11'd1;

      if ((state == ST_XFER) && sof_due)
        sof_late_o <= 1'b1;
    end
  end

  always_comb begin
    utmi_data_o    = 8'h00;
    utmi_txvalid_o = 1'b0;
    xfer_gnt_o     = 1'b0;
    xfer_txready_o = 1'b0;
    case (state)
      ST_SOF_PID: begin
        utmi_data_o    = PID_SOF;
        utmi_txvalid_o = 1'b1;
      end
      ST_SOF_B1: begin
        utmi_data_o    = frame_o[7:0];
        utmi_txvalid_o = 1'b1;
      end
      ST_SOF_B2: begin
        utmi_data_o    = {crc5, frame_o[10:8]};
        utmi_txvalid_o = 1'b1;
      end
      ST_XFER: begin
        xfer_gnt_o     = 1'b1;
        utmi_data_o    = xfer_data_i;
        utmi_txvalid_o = xfer_txvalid_i;
        xfer_txready_o = utmi_txready_i;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_usbh_frame_scheduler.sv
// Directed bench for usbh_frame_scheduler with a shortened 24-cycle frame.
// Expected bytes come from an independent reflected-CRC5 reference.
module tb_usbh_frame_scheduler;

  localparam int FC = 24;

  logic        clk_i = 1'b0;
  logic        n_rst_i;
  logic        sof_en_i;
  logic        xfer_req_i;
  logic        xfer_gnt_o;
  logic        xfer_done_i;
  logic [7:0]  xfer_data_i;
  logic        xfer_txvalid_i;
  logic        xfer_txready_o;
  logic [7:0]  utmi_data_o;
  logic        utmi_txvalid_o;
  logic        utmi_txready_i;
  logic [10:0] frame_o;
  logic        sof_o;
  logic        sof_late_o;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int last_sof;

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  usbh_frame_scheduler #(.USB_CLK_FREQ(24000), .EOF_GUARD(6)) dut (
    .clk_i          (clk_i),
    .n_rst_i        (n_rst_i),
    .sof_en_i       (sof_en_i),
    .xfer_req_i     (xfer_req_i),
    .xfer_gnt_o     (xfer_gnt_o),
    .xfer_done_i    (xfer_done_i),
    .xfer_data_i    (xfer_data_i),
    .xfer_txvalid_i (xfer_txvalid_i),
    .xfer_txready_o (xfer_txready_o),
    .utmi_data_o    (utmi_data_o),
    .utmi_txvalid_o (utmi_txvalid_o),
    .utmi_txready_i (utmi_txready_i),
    .frame_o        (frame_o),
    .sof_o          (sof_o),
    .sof_late_o     (sof_late_o)
  );

  task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Right-shifting form of the same CRC; final register inverted equals the wire order.
  function automatic logic [4:0] crc5_ref(input logic [10:0] d);
    logic [4:0] c;
    c = 5'h1f;
    for (int i = 0; i < 11; i++) begin
      if (c[0] ^ d[i]) c = (c >> 1) ^ 5'h14;
      else             c = c >> 1;
    end
    return ~c;
  endfunction

  task automatic wait_sof_start();
    int n;
    n = 0;
    while (utmi_txvalid_o !== 1'b1 && n < 3*FC) begin
      tick();
      n++;
    end
    chk("sof_start", 16'(utmi_txvalid_o), 16'd1);
  endtask

  task automatic sof_packet(input logic [10:0] fr);
    logic [10:0] nxt;
    nxt = fr + 11'd1;
    wait_sof_start();
    chk("pid", 16'(utmi_data_o), 16'h00A5);
    tick();
    chk("b1", 16'(utmi_data_o), 16'(fr[7:0]));
    tick();
    chk("b2", 16'(utmi_data_o), 16'({crc5_ref(fr), fr[10:8]}));
    tick();
    chk("sof_pulse", 16'(sof_o), 16'd1);
    chk("frame", 16'(frame_o), 16'(nxt));
  endtask

  initial begin
    n_rst_i = 1'b0; sof_en_i = 1'b0; xfer_req_i = 1'b0; xfer_done_i = 1'b0;
    xfer_data_i = 8'h00; xfer_txvalid_i = 1'b0; utmi_txready_i = 1'b0;

    #12;
    chk("rst_txvalid", 16'(utmi_txvalid_o), 16'd0);
    chk("rst_data",    16'(utmi_data_o),    16'd0);
    chk("rst_gnt",     16'(xfer_gnt_o),     16'd0);
    chk("rst_txready", 16'(xfer_txready_o), 16'd0);
    chk("rst_frame",   16'(frame_o),        16'd0);
    chk("rst_sof",     16'(sof_o),          16'd0);
    chk("rst_late",    16'(sof_late_o),     16'd0);

    // First SOF right after enable: A5, 00, 10
    @(negedge clk_i);
    n_rst_i = 1'b1; sof_en_i = 1'b1; utmi_txready_i = 1'b1;
    tick();
    chk("first_idle", 16'(utmi_txvalid_o), 16'd0);
    tick();
    chk("first_pid_v", 16'(utmi_txvalid_o), 16'd1);
    chk("first_pid",   16'(utmi_data_o),    16'h00A5);
    tick();
    chk("first_b1", 16'(utmi_data_o), 16'h0000);
    tick();
    chk("first_b2", 16'(utmi_data_o), 16'h0010);
    tick();
    chk("first_sof",   16'(sof_o),          16'd1);
    chk("first_frame", 16'(frame_o),        16'd1);
    chk("first_end_v", 16'(utmi_txvalid_o), 16'd0);
    tick();
    chk("first_sof_1cyc", 16'(sof_o), 16'd0);

    // Frame period and frame number wrap 2047 -> 0
    for (int f = 1; f < 2048; f++) begin
      sof_packet(11'(f));
      if (f > 1) chk("period", 16'(cyc - last_sof), 16'(FC));
      last_sof = cyc;
    end
    chk("wrap_frame", 16'(frame_o), 16'd0);

    // Guard window: timer is 4 on the sof_o cycle, request at timer 18
    repeat (14) tick();
    xfer_req_i = 1'b1;
    #1;
    chk("guard_nognt", 16'(xfer_gnt_o), 16'd0);
    repeat (5) tick();
    chk("guard_nognt_eof", 16'(xfer_gnt_o), 16'd0);
    sof_packet(11'd0);
    chk("guard_gnt_sofcyc", 16'(xfer_gnt_o), 16'd0);
    tick();
    chk("guard_gnt", 16'(xfer_gnt_o), 16'd1);
    xfer_data_i = 8'h3C; xfer_txvalid_i = 1'b1; utmi_txready_i = 1'b0;
    #1;
    chk("xfer_data",    16'(utmi_data_o),    16'h003C);
    chk("xfer_valid",   16'(utmi_txvalid_o), 16'd1);
    chk("xfer_rdy_lo",  16'(xfer_txready_o), 16'd0);
    utmi_txready_i = 1'b1;
    #1;
    chk("xfer_rdy_hi",  16'(xfer_txready_o), 16'd1);
    xfer_done_i = 1'b1;
    tick();
    xfer_done_i = 1'b0; xfer_req_i = 1'b0;
    #1;
    chk("done_gnt",     16'(xfer_gnt_o),     16'd0);
    chk("done_valid",   16'(utmi_txvalid_o), 16'd0);
    chk("done_data",    16'(utmi_data_o),    16'd0);
    chk("done_rdy",     16'(xfer_txready_o), 16'd0);

    // Collision: request raised on the timer-0 cycle when sof_due is set
    repeat (18) tick();
    xfer_req_i = 1'b1;
    #1;
    chk("coll_nognt", 16'(xfer_gnt_o), 16'd0);
    sof_packet(11'd1);
    chk("coll_nognt_sof", 16'(xfer_gnt_o), 16'd0);
    tick();
    chk("coll_gnt",  16'(xfer_gnt_o),  16'd1);
    chk("coll_late", 16'(sof_late_o),  16'd0);

    // Overrun: hold the transfer across the frame wrap
    xfer_txvalid_i = 1'b0;
    repeat (22) tick();
    chk("ovr_late",  16'(sof_late_o),     16'd1);
    chk("ovr_gnt",   16'(xfer_gnt_o),     16'd1);
    chk("ovr_valid", 16'(utmi_txvalid_o), 16'd0);
    xfer_done_i = 1'b1;
    tick();
    xfer_done_i = 1'b0; xfer_req_i = 1'b0;
    #1;
    chk("ovr_idle_gnt", 16'(xfer_gnt_o),     16'd0);
    chk("ovr_idle_v",   16'(utmi_txvalid_o), 16'd0);
    tick();
    chk("ovr_pid_v", 16'(utmi_txvalid_o), 16'd1);
    chk("ovr_pid",   16'(utmi_data_o),    16'h00A5);
    tick();
    chk("ovr_b1", 16'(utmi_data_o), 16'h0002);

    // Async reset in SOF_B1
    #2;
    n_rst_i = 1'b0;
    #1;
    chk("arst_valid", 16'(utmi_txvalid_o), 16'd0);
    chk("arst_frame", 16'(frame_o),        16'd0);
    chk("arst_data",  16'(utmi_data_o),    16'd0);
    chk("arst_late",  16'(sof_late_o),     16'd0);
    tick();
    chk("arst_nosof", 16'(sof_o), 16'd0);
    #4;
    n_rst_i = 1'b1;

    // Enable drops mid-packet: packet completes, nothing further starts
    wait_sof_start();
    chk("off_pid", 16'(utmi_data_o), 16'h00A5);
    sof_en_i = 1'b0;
    tick();
    chk("off_b1", 16'(utmi_data_o), 16'h0000);
    tick();
    chk("off_b2", 16'(utmi_data_o), 16'h0010);
    tick();
    chk("off_sof",   16'(sof_o),   16'd1);
    chk("off_frame", 16'(frame_o), 16'd1);
    begin
      int busy;
      busy = 0;
      for (int i = 0; i < 3*FC; i++) begin
        tick();
        if (utmi_txvalid_o) busy++;
      end
      chk("off_quiet", 16'(busy), 16'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
